seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised Moore-style serial sequence detector, successor to the fixed 3-bit "101" detector in the FSM collection. It watches a 1-bit serial stream and flags every occurrence of a runtime-loadable PAT_LEN-bit pattern. Overlapping or non-overlapping detection is selectable per bit, and input bits can be stalled with a valid qualifier. An optional saturating match counter is available for stream statistics in the protocol-monitor path.

## Interface
- PAT_LEN, 3, pattern length in bits; legal range 2..32
- PAT_RST, 3'b101 (PAT_LEN bits), pattern loaded at reset
- CNT_W, 8, match-counter width; only used when the counter is compiled in
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- x  input  1  serial data bit; MSB of the pattern arrives first
- x_vld  input  1  qualifies x; bit is consumed only when 1
- ovl  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each consumed bit
- pat_ld  input  1  load strobe for pat_in
- pat_in  input  PAT_LEN  new pattern
- cnt_clr  input  1  synchronous clear of match count (counter builds only)
- y  output  1  registered match flag
- match_cnt  output  CNT_W  saturating match count (counter builds only)

## Operation
- State:
  - pat register (PAT_LEN bits).
  - hist shift register (PAT_LEN-1 bits), holding the most recent consumed bits, newest in the LSB.
  - fill counter (0..PAT_LEN-1, clog2(PAT_LEN) bits), counting valid bits held in hist, saturating at PAT_LEN-1.
- Consumed bit (x_vld=1, pat_ld=0):
  - hit = (fill == PAT_LEN-1) && ({hist, x} == pat).
  - If hit and ovl=1: hist shifts in x; fill stays PAT_LEN-1.
  - If hit and ovl=0: hist is cleared and fill is set to 0. The next match needs PAT_LEN fresh bits.
  - If no hit: hist shifts in x; fill increments (saturating).
- Idle cycle (x_vld=0): hist, fill and pat hold; y deasserts.
- Pattern load (pat_ld=1): pat takes pat_in; hist and fill are cleared; x is ignored even if x_vld=1 (pat_ld wins); y goes to 0.
- Reset: pat=PAT_RST, hist=0, fill=0, y=0, match_cnt=0. Reset mid-stream discards any partial match; no y pulse is generated for a pattern straddling reset.

## Timing
- y is a pure register: y <= hit on every clock. It is high for exactly one cycle, the cycle after the edge that consumed the completing bit (Moore latency 1). It is never held across idle cycles.
- Back-to-back overlapping matches (e.g. "10101" vs "101") give y pulses 2 consumed bits apart with no gap cycles required.
- Valid gaps inside a pattern do not break it; only consumed bits count.
- The first possible hit is on the PAT_LEN-th consumed bit after reset, load, or a non-overlapping hit.
- match_cnt increments on the same edge that sets y. It saturates at 2^CNT_W-1.
- cnt_clr has priority over a simultaneous hit: the count becomes 0 and that match is not counted. y still pulses.

## Configuration
- SEQDET_MATCH_CNT_EN defined: the counter, cnt_clr and match_cnt ports exist, with the behaviour above.
- SEQDET_MATCH_CNT_EN undefined: the counter and both ports are removed. y and the detection behaviour are identical.

## Structure
- Shared package seq_det_pkg holds:
  - PAT_LEN_MAX = 32.
  - The default pattern constant 3'b101.
  - A function computing the fill width from PAT_LEN.
- One sub-module, seq_hist: the PAT_LEN-1 history shift register plus fill counter, with shift/clear/hold controls. The top holds pat, the compare, y and the optional counter.

## Test plan
- Reset, PAT_LEN=3, defaults, ovl=1, stream 1,0,1,0,1 every cycle → y high in cycles after bits 3 and 5 only; match_cnt=2.
- Same stream with ovl=0 → y only after bit 3; a further 0,1 → y after bit 7 (bits 5,6,7 = 1,0,1); match_cnt=2.
- PAT_LEN=4, pat_ld with pat_in=4'b1101 asserted together with x_vld=1 → that bit dropped; then stream 1,1,0,1 → single y pulse after the 4th bit.
- Stream 1,(x_vld=0 for 3 cycles),0,1 → y pulses once, one cycle after the final 1; y=0 during the gaps.
- CNT_W=2, five overlapping "101" matches → match_cnt reaches 3 and holds. cnt_clr on the same edge as a hit → match_cnt=0 and y=1.
- rst pulsed after 1,0 of "101" then stream continues 1 → no y pulse. After reset, pat equals 3'b101 and match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int PAT_LEN_MAX = 32;
  localparam logic [2:0] PAT_DEFAULT = 3'b101;

  // Fill counter must represent 0..PAT_LEN-1; never narrower than one bit.
  function automatic int fill_w(input int pat_len);
    return (pat_len <= 2) ? 1 : $clog2(pat_len);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// seq_hist: history shift register (newest bit in LSB) plus saturating fill count.
// Updates on the next edge. Hold when idle. Clear has priority over shift.
module seq_hist #(
  parameter int PAT_LEN = 3,
  parameter int FW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clr,
  input  logic               din,
  output logic [PAT_LEN-2:0] hist,
  output logic [FW-1:0]      fill
);

  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] ext;
  assign ext = {hist, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= ext[PAT_LEN-2:0];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable PAT_LEN-bit serial pattern detector; y is registered, one cycle after the completing bit.
// x_vld stalls the stream without breaking a match. Optional counter via SEQDET_MATCH_CNT_EN.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_DEFAULT),
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_vld,
  input  logic               ovl,
  input  logic               pat_ld,
  input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQDET_MATCH_CNT_EN
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               y
);

  localparam int FW = fill_w(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: illegal PAT_LEN or CNT_W");
  end

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic               consume;
  logic               hit;
  logic               h_shift;
  logic               h_clr;

  assign consume = x_vld & ~pat_ld;
  assign hit     = consume && (fill == FW'(PAT_LEN - 1)) && ({hist, x} == pat);
  // An overlapping hit is just a shift; fill is already saturated.
  assign h_shift = consume & ~(hit & ~ovl);
  assign h_clr   = pat_ld | (hit & ~ovl);

  seq_hist #(
    .PAT_LEN (PAT_LEN),
    .FW      (FW)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .shift (h_shift),
    .clr   (h_clr),
    .din   (x),
    .hist  (hist),
    .fill  (fill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= PAT_RST;
      y   <= 1'b0;
    end else begin
      if (pat_ld) pat <= pat_in;
      y <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a PAT_LEN=3 (CNT_W=2) instance and a PAT_LEN=4 instance.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_vld = 1'b0;
  logic       ovl = 1'b1;
  logic       pat_ld3 = 1'b0;
  logic [2:0] pat_in3 = 3'b000;
  logic       pat_ld4 = 1'b0;
  logic [3:0] pat_in4 = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       y3;
  logic       y4;
`ifdef SEQDET_MATCH_CNT_EN
  logic [1:0] cnt3;
  logic [7:0] cnt4;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(3), .CNT_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .ovl       (ovl),
    .pat_ld    (pat_ld3),
    .pat_in    (pat_in3),
`ifdef SEQDET_MATCH_CNT_EN
    .cnt_clr   (cnt_clr),
    .match_cnt (cnt3),
`endif
    .y         (y3)
  );

  seq_detect_param #(.PAT_LEN(4), .PAT_RST(4'b0000)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .ovl       (ovl),
    .pat_ld    (pat_ld4),
    .pat_in    (pat_in4),
`ifdef SEQDET_MATCH_CNT_EN
    .cnt_clr   (cnt_clr),
    .match_cnt (cnt4),
`endif
    .y         (y4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; x = 1'b0; x_vld = 1'b0; cnt_clr = 1'b0;
    pat_ld3 = 1'b0; pat_ld4 = 1'b0;
    @(posedge clk); #1;
    check("rst_y3", 32'(y3), 32'd0);
    check("rst_y4", 32'(y4), 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
    check("rst_cnt3", 32'(cnt3), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle, then check the PAT_LEN=3 detector's y.
  task automatic step3(input string tag, input logic xb, input logic vb, input logic ey);
    @(negedge clk);
    x = xb; x_vld = vb;
    @(posedge clk); #1;
    check(tag, 32'(y3), 32'(ey));
  endtask

  task automatic step4(input string tag, input logic xb, input logic vb, input logic ey);
    @(negedge clk);
    x = xb; x_vld = vb;
    @(posedge clk); #1;
    check(tag, 32'(y4), 32'(ey));
  endtask

  logic s1 [5]  = '{1, 0, 1, 0, 1};
  logic e1 [5]  = '{0, 0, 1, 0, 1};
  logic s2 [7]  = '{1, 0, 1, 0, 1, 0, 1};
  logic e2 [7]  = '{0, 0, 1, 0, 0, 0, 1};
  logic s4 [4]  = '{1, 1, 0, 1};
  logic e4 [4]  = '{0, 0, 0, 1};
  logic gx [6]  = '{1, 0, 0, 0, 0, 1};
  logic gv [6]  = '{1, 0, 0, 0, 1, 1};
  logic ge [6]  = '{0, 0, 0, 0, 0, 1};

  initial begin
    // Overlapping "101" detection.
    do_reset();
    ovl = 1'b1;
    for (int i = 0; i < 5; i++) step3($sformatf("ovl_y%0d", i + 1), s1[i], 1'b1, e1[i]);
`ifdef SEQDET_MATCH_CNT_EN
    check("ovl_cnt", 32'(cnt3), 32'd2);
`endif

    // Non-overlapping: the middle 1 cannot start a new match.
    do_reset();
    ovl = 1'b0;
    for (int i = 0; i < 7; i++) step3($sformatf("novl_y%0d", i + 1), s2[i], 1'b1, e2[i]);
`ifdef SEQDET_MATCH_CNT_EN
    check("novl_cnt", 32'(cnt3), 32'd2);
`endif

    // PAT_LEN=4 load: the bit presented alongside pat_ld is dropped.
    do_reset();
    ovl = 1'b1;
    @(negedge clk);
    pat_ld4 = 1'b1; pat_in4 = 4'b1101; x = 1'b1; x_vld = 1'b1;
    @(posedge clk); #1;
    check("ld_y4", 32'(y4), 32'd0);
    @(negedge clk);
    pat_ld4 = 1'b0;
    for (int i = 0; i < 4; i++) step4($sformatf("p4_y%0d", i + 1), s4[i], 1'b1, e4[i]);
    step4("p4_idle", 1'b1, 1'b0, 1'b0);

    // Valid gaps inside a pattern; y never held across idle cycles.
    do_reset();
    for (int i = 0; i < 6; i++) step3($sformatf("gap_y%0d", i + 1), gx[i], gv[i], ge[i]);
    step3("gap_idle", 1'b1, 1'b0, 1'b0);

`ifdef SEQDET_MATCH_CNT_EN
    // Counter saturation at 3 over five overlapping matches, then clear on a hit.
    do_reset();
    ovl = 1'b1;
    step3("sat_b1", 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 5; m++) begin
      step3($sformatf("sat_z%0d", m), 1'b0, 1'b1, 1'b0);
      step3($sformatf("sat_h%0d", m), 1'b1, 1'b1, 1'b1);
    end
    check("sat_cnt", 32'(cnt3), 32'd3);
    step3("clr_z", 1'b0, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    step3("clr_hit_y", 1'b1, 1'b1, 1'b1);
    check("clr_hit_cnt", 32'(cnt3), 32'd0);
    cnt_clr = 1'b0;
    step3("clr_z2", 1'b0, 1'b1, 1'b0);
    step3("clr_h2", 1'b1, 1'b1, 1'b1);
    check("clr_recount", 32'(cnt3), 32'd1);
`endif

    // Reset mid-pattern discards the partial "10".
    do_reset();
    ovl = 1'b1;
    step3("mid_b1", 1'b1, 1'b1, 1'b0);
    step3("mid_b2", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; x_vld = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_y", 32'(y3), 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
    check("mid_rst_cnt", 32'(cnt3), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step3("mid_b3", 1'b1, 1'b1, 1'b0);
    step3("mid_b4", 1'b0, 1'b1, 1'b0);
    step3("mid_b5", 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
